// File: rtl/cordic_vectoring_engine_if.sv
// Handshake bundle for cordic_vectoring_engine: vector request side and
// magnitude/angle result side, each with its own valid/ready pair.
interface cordic_vectoring_engine_if #(
    parameter int VALUE_WIDTH   = 12,
    parameter int ADDRESS_WIDTH = 12
);
    logic                            in_valid;
    logic                            in_ready;
    logic signed [VALUE_WIDTH:0]     x_in;
    logic signed [VALUE_WIDTH:0]     y_in;
    logic                            out_valid;
    logic                            out_ready;
    logic        [VALUE_WIDTH+1:0]   mag_out;
    logic signed [ADDRESS_WIDTH+1:0] angle_out;

    modport master (
        output in_valid, x_in, y_in, out_ready,
        input  in_ready, out_valid, mag_out, angle_out
    );

    modport slave (
        input  in_valid, x_in, y_in, out_ready,
        output in_ready, out_valid, mag_out, angle_out
    );
endinterface

// File: rtl/cordic_vectoring_engine.sv
// Iterative vectoring-mode CORDIC: (x, y) -> magnitude and atan2 angle over one shared datapath.
// Define CORDIC_GAIN_COMP_EN to add a GAIN state that scales the magnitude by ~1/K.
module cordic_vectoring_engine #(
    parameter int VALUE_WIDTH   = 12,
    parameter int ADDRESS_WIDTH = 12,
    parameter int ITERATIONS    = ADDRESS_WIDTH
) (
    input  logic CLK,
    input  logic RESET,
    cordic_vectoring_engine_if.slave bus
);
    localparam int XW    = VALUE_WIDTH + 3;
    localparam int ZW    = ADDRESS_WIDTH + 2;
    localparam int KW    = 5;
    localparam int SHIFT = 16 - ADDRESS_WIDTH;
    localparam int HALF  = (SHIFT == 0) ? 0 : (1 << (SHIFT - 1));

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_GAIN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // atan(2^-k) with 180 deg = 2^17, rescaled to the configured angle resolution
    function automatic logic [ZW-1:0] atan_code(input logic [KW-1:0] k);
        logic [16:0] base_s;
        logic [16:0] rnd_s;
        case (k)
            5'd0:    base_s = 17'd32768;
            5'd1:    base_s = 17'd19344;
            5'd2:    base_s = 17'd10221;
            5'd3:    base_s = 17'd5188;
            5'd4:    base_s = 17'd2604;
            5'd5:    base_s = 17'd1303;
            5'd6:    base_s = 17'd652;
            5'd7:    base_s = 17'd326;
            5'd8:    base_s = 17'd163;
            5'd9:    base_s = 17'd81;
            5'd10:   base_s = 17'd41;
            5'd11:   base_s = 17'd20;
            5'd12:   base_s = 17'd10;
            5'd13:   base_s = 17'd5;
            5'd14:   base_s = 17'd3;
            5'd15:   base_s = 17'd1;
            default: base_s = 17'd0;
        endcase
        rnd_s = (base_s + 17'(HALF)) >> SHIFT;
        return ZW'(rnd_s);
    endfunction

    state_t                state_r, state_nxt_s;
    logic [KW-1:0]         k_r;
    logic signed [XW-1:0]  x_r, y_r;
    logic signed [ZW-1:0]  z_r;
    logic                  zero_r;
    logic                  out_valid_r;
    logic [VALUE_WIDTH+1:0] mag_r;
    logic signed [ZW-1:0]  ang_r;
    logic                  in_ready_r;

    logic                  accept_s, last_s, release_s, load_out_s;
    logic signed [XW-1:0]  x_ext_s, y_ext_s, x_fold_s, y_fold_s;
    logic signed [ZW-1:0]  z_fold_s;
    logic signed [XW-1:0]  x_sh_s, y_sh_s, x_step_s, y_step_s;
    logic [ZW-1:0]         e_s;
    logic signed [ZW-1:0]  z_step_s;
    logic signed [XW-1:0]  res_x_s;
    logic signed [ZW-1:0]  res_z_s;

    assign accept_s   = bus.in_valid & bus.in_ready;
    assign last_s     = (k_r == KW'(ITERATIONS - 1));
    assign release_s  = out_valid_r & bus.out_ready;
    assign load_out_s = (state_nxt_s == ST_DONE) && (state_r != ST_DONE);

    assign bus.in_ready  = in_ready_r & ~RESET;
    assign bus.out_valid = out_valid_r;
    assign bus.mag_out   = mag_r;
    assign bus.angle_out = ang_r;

    // Left half-plane inputs are rotated by 180 deg so the iterations only see x >= 0
    always_comb begin
        x_ext_s = {{2{bus.x_in[VALUE_WIDTH]}}, bus.x_in};
        y_ext_s = {{2{bus.y_in[VALUE_WIDTH]}}, bus.y_in};
        if (bus.x_in[VALUE_WIDTH]) begin
            x_fold_s = -x_ext_s;
            y_fold_s = -y_ext_s;
            z_fold_s = {1'b1, {(ZW-1){1'b0}}};
        end else begin
            x_fold_s = x_ext_s;
            y_fold_s = y_ext_s;
            z_fold_s = {ZW{1'b0}};
        end
    end

    // One micro-rotation driving y towards zero, using pre-step values only
    always_comb begin
        x_sh_s = x_r >>> k_r;
        y_sh_s = y_r >>> k_r;
        e_s    = atan_code(k_r);
        if (y_r[XW-1]) begin
            x_step_s = x_r - y_sh_s;
            y_step_s = y_r + x_sh_s;
            z_step_s = z_r - e_s;
        end else begin
            x_step_s = x_r + y_sh_s;
            y_step_s = y_r - x_sh_s;
            z_step_s = z_r + e_s;
        end
    end

    // Result source: gain-compensated stored vector, or the final micro-rotation directly
    always_comb begin
`ifdef CORDIC_GAIN_COMP_EN
        res_x_s = (x_r >>> 1) + (x_r >>> 3) - (x_r >>> 6) - (x_r >>> 9);
        res_z_s = z_r;
`else
        res_x_s = x_step_s;
        res_z_s = z_step_s;
`endif
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = ST_ITER;
                else          state_nxt_s = ST_IDLE;
            end
            ST_ITER: begin
                if (last_s) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_nxt_s = ST_GAIN;
`else
                    state_nxt_s = ST_DONE;
`endif
                end else begin
                    state_nxt_s = ST_ITER;
                end
            end
            ST_GAIN: state_nxt_s = ST_DONE;
            ST_DONE: begin
                if (release_s) state_nxt_s = ST_IDLE;
                else           state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) state_r <= ST_IDLE;
        else       state_r <= state_nxt_s;
    end

    // Working vector, angle accumulator and iteration counter
    always_ff @(posedge CLK) begin
        if (RESET) begin
            k_r    <= {KW{1'b0}};
            x_r    <= {XW{1'b0}};
            y_r    <= {XW{1'b0}};
            z_r    <= {ZW{1'b0}};
            zero_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        x_r    <= x_fold_s;
                        y_r    <= y_fold_s;
                        z_r    <= z_fold_s;
                        k_r    <= {KW{1'b0}};
                        zero_r <= (bus.x_in == {(VALUE_WIDTH+1){1'b0}}) &&
                                  (bus.y_in == {(VALUE_WIDTH+1){1'b0}});
                    end
                end
                ST_ITER: begin
                    x_r <= x_step_s;
                    y_r <= y_step_s;
                    z_r <= z_step_s;
                    k_r <= k_r + 5'd1;
                end
                default: begin
                    k_r <= k_r;
                end
            endcase
        end
    end

    // Result registers hold steady through DONE until the consumer takes them
    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_valid_r <= 1'b0;
            mag_r       <= {(VALUE_WIDTH+2){1'b0}};
            ang_r       <= {ZW{1'b0}};
            in_ready_r  <= 1'b1;
        end else begin
            in_ready_r <= (state_nxt_s == ST_IDLE);
            if (load_out_s) begin
                out_valid_r <= 1'b1;
                if (zero_r || res_x_s[XW-1]) mag_r <= {(VALUE_WIDTH+2){1'b0}};
                else                         mag_r <= res_x_s[XW-2:0];
                if (zero_r) ang_r <= {ZW{1'b0}};
                else        ang_r <= res_z_s;
            end else if (release_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end
endmodule
